data_ram_arbiter: RTL and testbench

DATA_RAM_ARBITER -- requirements
Module: data_ram_arbiter

---
 rtl/data_ram_arbiter.sv | 141 ++++++++++++++
 tb/tb_data_ram_arbiter.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/data_ram_arbiter.sv
// Two-port round-robin arbiter that shares one registered-read BlockRam between cores A and B.
// Each access takes three cycles: grant/latch, RAM access, then read-data capture and ack.
module data_ram_arbiter #(
   parameter int unsigned WORD_WIDTH    = 32,
   parameter int unsigned ADDRESS_WIDTH = 16
) (
   input  logic                     clock,
   input  logic                     reset_n,
   input  logic                     a_req,
   input  logic                     a_write,
   input  logic [ADDRESS_WIDTH-1:0] a_address,
   input  logic [WORD_WIDTH-1:0]    a_write_data,
   output logic                     a_ack,
   output logic [WORD_WIDTH-1:0]    a_read_data,
   output logic                     a_grant,
   input  logic                     b_req,
   input  logic                     b_write,
   input  logic [ADDRESS_WIDTH-1:0] b_address,
   input  logic [WORD_WIDTH-1:0]    b_write_data,
   output logic                     b_ack,
   output logic [WORD_WIDTH-1:0]    b_read_data,
   output logic                     b_grant,
   output logic [ADDRESS_WIDTH-1:0] ram_address,
   output logic                     ram_write,
   output logic [WORD_WIDTH-1:0]    ram_write_data,
   input  logic [WORD_WIDTH-1:0]    ram_read_data
);

   typedef enum logic [1:0] {StIdle, StAccess, StCapture} state_e;

   state_e                   state_q, state_d;
   logic                     last_grant_q, last_grant_d;  // 1 = B granted last
   logic                     owner_q, owner_d;            // 1 = B owns the current access
   logic [ADDRESS_WIDTH-1:0] ram_address_q, ram_address_d;
   logic                     ram_write_q, ram_write_d;
   logic [WORD_WIDTH-1:0]    ram_write_data_q, ram_write_data_d;
   logic                     a_ack_q, a_ack_d, b_ack_q, b_ack_d;
   logic                     a_grant_q, a_grant_d, b_grant_q, b_grant_d;
   logic [WORD_WIDTH-1:0]    a_read_data_q, a_read_data_d, b_read_data_q, b_read_data_d;

   logic                     eligible_a, eligible_b, pick_a, pick_b;
   logic [ADDRESS_WIDTH-1:0] a_word_address, b_word_address;

   // Byte address to word address; the two low bits are dropped without any alignment check.
   assign a_word_address = {2'b00, a_address[ADDRESS_WIDTH-1:2]};
   assign b_word_address = {2'b00, b_address[ADDRESS_WIDTH-1:2]};

   // A port whose ack is high this cycle sits out one arbitration round.
   assign eligible_a = a_req & ~a_ack_q;
   assign eligible_b = b_req & ~b_ack_q;
   assign pick_a     = eligible_a & (~eligible_b | last_grant_q);
   assign pick_b     = eligible_b & ~pick_a;

   always_comb begin
      state_d          = state_q;
      last_grant_d     = last_grant_q;
      owner_d          = owner_q;
      ram_address_d    = ram_address_q;
      ram_write_d      = ram_write_q;
      ram_write_data_d = ram_write_data_q;
      a_ack_d          = 1'b0;
      b_ack_d          = 1'b0;
      a_grant_d        = a_grant_q;
      b_grant_d        = b_grant_q;
      a_read_data_d    = a_read_data_q;
      b_read_data_d    = b_read_data_q;

      unique case (state_q)
         StIdle: begin
            if (pick_a || pick_b) begin
               owner_d          = pick_b;
               last_grant_d     = pick_b;
               ram_address_d    = pick_b ? b_word_address : a_word_address;
               ram_write_d      = pick_b ? b_write : a_write;
               ram_write_data_d = pick_b ? b_write_data : a_write_data;
               a_grant_d        = pick_a;
               b_grant_d        = pick_b;
               state_d          = StAccess;
            end
         end
         StAccess: begin
            ram_write_d = 1'b0;
            state_d     = StCapture;
         end
         StCapture: begin
            if (owner_q) begin
               b_read_data_d = ram_read_data;
               b_ack_d       = 1'b1;
               b_grant_d     = 1'b0;
            end else begin
               a_read_data_d = ram_read_data;
               a_ack_d       = 1'b1;
               a_grant_d     = 1'b0;
            end
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q          <= StIdle;
         last_grant_q     <= 1'b1;
         owner_q          <= 1'b0;
         ram_address_q    <= '0;
         ram_write_q      <= 1'b0;
         ram_write_data_q <= '0;
         a_ack_q          <= 1'b0;
         b_ack_q          <= 1'b0;
         a_grant_q        <= 1'b0;
         b_grant_q        <= 1'b0;
         a_read_data_q    <= '0;
         b_read_data_q    <= '0;
      end else begin
         state_q          <= state_d;
         last_grant_q     <= last_grant_d;
         owner_q          <= owner_d;
         ram_address_q    <= ram_address_d;
         ram_write_q      <= ram_write_d;
         ram_write_data_q <= ram_write_data_d;
         a_ack_q          <= a_ack_d;
         b_ack_q          <= b_ack_d;
         a_grant_q        <= a_grant_d;
         b_grant_q        <= b_grant_d;
         a_read_data_q    <= a_read_data_d;
         b_read_data_q    <= b_read_data_d;
      end
   end

   assign ram_address    = ram_address_q;
   assign ram_write      = ram_write_q;
   assign ram_write_data = ram_write_data_q;
   assign a_ack          = a_ack_q;
   assign b_ack          = b_ack_q;
   assign a_grant        = a_grant_q;
   assign b_grant        = b_grant_q;
   assign a_read_data    = a_read_data_q;
   assign b_read_data    = b_read_data_q;

endmodule

// File: tb/tb_data_ram_arbiter.sv
// Directed bench for data_ram_arbiter with a registered-read RAM model; every unwritten word
// reads back as 32'hA000_0000 + word index.
module tb_data_ram_arbiter;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        a_req = 1'b0, a_write = 1'b0, b_req = 1'b0, b_write = 1'b0;
   logic [15:0] a_address = '0, b_address = '0;
   logic [31:0] a_write_data = '0, b_write_data = '0;
   logic        a_ack, b_ack, a_grant, b_grant, ram_write;
   logic [31:0] a_read_data, b_read_data, ram_write_data;
   logic [15:0] ram_address;
   logic [31:0] ram_read_data;

   int checks = 0;
   int errors = 0;
   int violations = 0;
   int gseq [8];
   int gcount;
   logic prev_a, prev_b;

   logic        mem_clear = 1'b1;
   logic [31:0] mem [256];
   logic [255:0] mem_valid;

   always #5 clock = ~clock;

   data_ram_arbiter #(.WORD_WIDTH(32), .ADDRESS_WIDTH(16)) dut (
      .clock(clock), .reset_n(reset_n),
      .a_req(a_req), .a_write(a_write), .a_address(a_address), .a_write_data(a_write_data),
      .a_ack(a_ack), .a_read_data(a_read_data), .a_grant(a_grant),
      .b_req(b_req), .b_write(b_write), .b_address(b_address), .b_write_data(b_write_data),
      .b_ack(b_ack), .b_read_data(b_read_data), .b_grant(b_grant),
      .ram_address(ram_address), .ram_write(ram_write), .ram_write_data(ram_write_data),
      .ram_read_data(ram_read_data)
   );

   // Read-before-write RAM with one cycle of read latency.
   always @(posedge clock) begin
      if (mem_clear) begin
         mem_valid     <= '0;
         ram_read_data <= '0;
      end else begin
         if (ram_write) begin
            mem[ram_address[7:0]]       <= ram_write_data;
            mem_valid[ram_address[7:0]] <= 1'b1;
         end
         ram_read_data <= mem_valid[ram_address[7:0]] ? mem[ram_address[7:0]]
                                                      : 32'hA000_0000 + 32'(ram_address[7:0]);
      end
   end

   always @(negedge clock) begin
      if (a_grant && b_grant) violations++;
      if (a_ack && b_ack) violations++;
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      a_req = 1'b0;
      b_req = 1'b0;
      step();
      step();
      reset_n = 1'b1;
   endtask

   initial begin
      do_reset();
      mem_clear = 1'b0;
      check("rst_a_ack", 32'(a_ack), 32'd0);
      check("rst_b_ack", 32'(b_ack), 32'd0);
      check("rst_grants", 32'({a_grant, b_grant}), 32'd0);
      check("rst_ram_write", 32'(ram_write), 32'd0);
      check("rst_ram_address", 32'(ram_address), 32'd0);
      check("rst_ram_wdata", ram_write_data, 32'd0);
      check("rst_a_rdata", a_read_data, 32'd0);
      check("rst_b_rdata", b_read_data, 32'd0);

      // Single store from A
      a_req = 1'b1; a_write = 1'b1; a_address = 16'h0010; a_write_data = 32'h1234_5678;
      step();
      a_req = 1'b0;
      check("st_a_grant", 32'(a_grant), 32'd1);
      check("st_ram_address", 32'(ram_address), 32'h0004);
      check("st_ram_write_1", 32'(ram_write), 32'd1);
      check("st_ram_wdata", ram_write_data, 32'h1234_5678);
      step();
      check("st_ram_write_2", 32'(ram_write), 32'd0);
      check("st_a_ack_early", 32'(a_ack), 32'd0);
      step();
      check("st_a_ack", 32'(a_ack), 32'd1);
      check("st_a_grant_clr", 32'(a_grant), 32'd0);
      check("st_b_ack", 32'(b_ack), 32'd0);
      check("st_a_rdata_old", a_read_data, 32'hA000_0004);
      step();
      check("st_a_ack_pulse", 32'(a_ack), 32'd0);

      // Load from B of the stored word
      b_req = 1'b1; b_write = 1'b0; b_address = 16'h0010; b_write_data = 32'hFFFF_FFFF;
      step();
      b_req = 1'b0;
      check("ld_b_grant", 32'(b_grant), 32'd1);
      check("ld_ram_write", 32'(ram_write), 32'd0);
      step();
      check("ld_ram_write_2", 32'(ram_write), 32'd0);
      step();
      check("ld_b_ack", 32'(b_ack), 32'd1);
      check("ld_b_rdata", b_read_data, 32'h1234_5678);
      check("ld_a_rdata_hold", a_read_data, 32'hA000_0004);

      // Simultaneous requests after reset: A first, then B, then a fresh tie goes to A
      do_reset();
      a_req = 1'b1; a_write = 1'b0; a_address = 16'h0020;
      b_req = 1'b1; b_write = 1'b0; b_address = 16'h0024;
      step();
      check("tie_a_grant", 32'({a_grant, b_grant}), 32'b10);
      step();
      step();
      check("tie_a_ack", 32'({a_ack, b_ack}), 32'b10);
      check("tie_a_rdata", a_read_data, 32'hA000_0008);
      a_req = 1'b0;
      step();
      check("tie_b_grant", 32'({a_grant, b_grant}), 32'b01);
      step();
      step();
      check("tie_b_ack", 32'({a_ack, b_ack}), 32'b01);
      check("tie_b_rdata", b_read_data, 32'hA000_0009);
      b_req = 1'b0;
      step();
      step();
      check("tie_idle", 32'({a_grant, b_grant}), 32'd0);
      a_req = 1'b1;
      b_req = 1'b1;
      step();
      a_req = 1'b0;
      b_req = 1'b0;
      check("tie3_a_grant", 32'({a_grant, b_grant}), 32'b10);
      step();
      step();
      step();

      // Continuous contention from reset: grants alternate A,B,A,B
      do_reset();
      gcount = 0;
      prev_a = 1'b0;
      prev_b = 1'b0;
      a_req = 1'b1;
      b_req = 1'b1;
      for (int i = 0; i < 12; i++) begin
         step();
         if (a_grant && !prev_a && gcount < 8) begin gseq[gcount] = 0; gcount++; end
         if (b_grant && !prev_b && gcount < 8) begin gseq[gcount] = 1; gcount++; end
         prev_a = a_grant;
         prev_b = b_grant;
      end
      a_req = 1'b0;
      b_req = 1'b0;
      check("cont_count", 32'(gcount), 32'd4);
      for (int i = 0; i < 4; i++) check($sformatf("cont_seq%0d", i), 32'(gseq[i]), 32'(i % 2));
      step();
      step();
      step();

      // Reset in the middle of a store
      a_req = 1'b1; a_write = 1'b1; a_address = 16'h0040; a_write_data = 32'hDEAD_BEEF;
      step();
      a_req = 1'b0;
      check("mid_ram_write", 32'(ram_write), 32'd1);
      reset_n = 1'b0;
      step();
      reset_n = 1'b1;
      check("mid_rst_ram_write", 32'(ram_write), 32'd0);
      check("mid_rst_grant", 32'(a_grant), 32'd0);
      step();
      check("mid_no_ack", 32'(a_ack), 32'd0);
      a_req = 1'b1; a_write = 1'b0; a_address = 16'h0044;
      step();
      a_req = 1'b0;
      step();
      step();
      check("mid_new_ack", 32'(a_ack), 32'd1);
      check("mid_new_rdata", a_read_data, 32'hA000_0011);

      // Unaligned load
      b_req = 1'b1; b_write = 1'b0; b_address = 16'h0013;
      step();
      b_req = 1'b0;
      check("ua_ram_address", 32'(ram_address), 32'h0004);
      step();
      step();
      check("ua_b_ack", 32'(b_ack), 32'd1);
      check("ua_b_rdata", b_read_data, 32'h1234_5678);
      step();

      check("mutex_violations", 32'(violations), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
